wmst_burst_writer: RTL and testbench

- Avalon-MM write-master datapath that sits directly downstream of the write-master tile controller.
- The controller issues one transaction at a time: byte address, word length and a start pulse. This block splits the transaction into Avalon bursts of at most BURST_LEN words and drains the store FIFO onto the bus.
- It returns a single-cycle store_trans_done when the last word is accepted.

---
 rtl/wmst_burst_writer.sv | 120 ++++++++++++
 tb/tb_wmst_burst_writer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wmst_burst_writer.sv
// Avalon-MM write master datapath: splits one transaction into bursts of at most
// BURST_LEN words and drains the show-ahead store FIFO onto the bus.
module wmst_burst_writer #(
   parameter int unsigned AW        = 12,
   parameter int unsigned DW        = 32,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned BCW       = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            store_trans_start,
   input  logic [DW-1:0]   param_waddr,
   input  logic [AW-1:0]   param_iolen,
   output logic            store_trans_done,
   input  logic [DW-1:0]   fifo_rdata,
   input  logic            fifo_empty,
   output logic            fifo_rd,
   output logic [DW-1:0]   avm_address,
   output logic [BCW-1:0]  avm_burstcount,
   output logic            avm_write,
   output logic [DW-1:0]   avm_writedata,
   output logic [DW/8-1:0] avm_byteenable,
   input  logic            avm_waitrequest
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state, state_d;
   logic [DW-1:0]  address_d;
   logic [BCW-1:0] burstcount_d;
   logic [AW-1:0]  remaining, remaining_d;
   logic [BCW-1:0] beat, beat_d;
   logic           done_d;
   logic           accept;
   logic           last_beat;

   // Bus handshake is combinational so a beat can be accepted every cycle.
   assign avm_write      = (state == WRITE) && !fifo_empty;
   assign accept         = avm_write && !avm_waitrequest;
   assign fifo_rd        = accept;
   assign avm_writedata  = fifo_rdata;
   assign avm_byteenable = '1;
   assign last_beat      = (beat + BCW'(1)) == avm_burstcount;

   always_comb begin
      state_d      = state;
      address_d    = avm_address;
      burstcount_d = avm_burstcount;
      remaining_d  = remaining;
      beat_d       = beat;
      done_d       = 1'b0;
      case (state)
         IDLE: begin
            if (store_trans_start) begin
               address_d   = param_waddr;
               remaining_d = param_iolen;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (remaining == '0) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               burstcount_d = (remaining >= AW'(BURST_LEN)) ? BCW'(BURST_LEN)
                                                           : BCW'(remaining);
               beat_d       = '0;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            if (accept) begin
               if (last_beat) begin
                  // Next burst starts right after this one; address wraps modulo 2^DW.
                  address_d   = avm_address + (DW'(avm_burstcount) << 2);
                  remaining_d = remaining - AW'(avm_burstcount);
                  if (remaining == AW'(avm_burstcount)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = SETUP;
                  end
               end else begin
                  beat_d = beat + BCW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         avm_address      <= '0;
         avm_burstcount   <= '0;
         remaining        <= '0;
         beat             <= '0;
         store_trans_done <= 1'b0;
      end else begin
         state            <= state_d;
         avm_address      <= address_d;
         avm_burstcount   <= burstcount_d;
         remaining        <= remaining_d;
         beat             <= beat_d;
         store_trans_done <= done_d;
      end
   end

endmodule

// File: tb/tb_wmst_burst_writer.sv
// Bench for wmst_burst_writer: transaction-level model of expected beats checked
// every cycle, plus literal expectations on burst addresses and counts.
`timescale 1ns/1ps
module tb_wmst_burst_writer;

   localparam int unsigned AW  = 12;
   localparam int unsigned DW  = 32;
   localparam int unsigned BCW = 5;
   localparam int          BL  = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            store_trans_start = 1'b0;
   logic [DW-1:0]   param_waddr = '0;
   logic [AW-1:0]   param_iolen = '0;
   logic            store_trans_done;
   logic [DW-1:0]   fifo_rdata = '0;
   logic            fifo_empty = 1'b1;
   logic            fifo_rd;
   logic [DW-1:0]   avm_address;
   logic [BCW-1:0]  avm_burstcount;
   logic            avm_write;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic            avm_waitrequest = 1'b0;

   logic            push_req = 1'b0;
   logic [DW-1:0]   push_val = '0;

   wmst_burst_writer #(.AW(AW), .DW(DW), .BURST_LEN(BL), .BCW(BCW)) dut (
      .clk              (clk),
      .rst              (rst),
      .store_trans_start(store_trans_start),
      .param_waddr      (param_waddr),
      .param_iolen      (param_iolen),
      .store_trans_done (store_trans_done),
      .fifo_rdata       (fifo_rdata),
      .fifo_empty       (fifo_empty),
      .fifo_rd          (fifo_rd),
      .avm_address      (avm_address),
      .avm_burstcount   (avm_burstcount),
      .avm_write        (avm_write),
      .avm_writedata    (avm_writedata),
      .avm_byteenable   (avm_byteenable),
      .avm_waitrequest  (avm_waitrequest)
   );

   always #5 clk = ~clk;

   // Show-ahead store FIFO: pop/push requests captured mid-cycle, applied on the edge.
   logic [DW-1:0] fifo_q[$];
   logic          pop_s = 1'b0;
   logic          push_s = 1'b0;
   logic [DW-1:0] pushv_s = '0;

   always @(negedge clk) begin
      pop_s   <= fifo_rd;
      push_s  <= push_req;
      pushv_s <= push_val;
   end

   always @(posedge clk) begin
      if (!rst) begin
         fifo_q.delete();
      end else begin
         if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (push_s) fifo_q.push_back(pushv_s);
      end
      fifo_empty <= (fifo_q.size() == 0);
      fifo_rdata <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   typedef struct {
      logic [DW-1:0]  addr;
      logic [BCW-1:0] bc;
      bit             last;
   } beat_t;

   typedef struct {
      logic [DW-1:0]  addr;
      logic [BCW-1:0] bc;
   } burst_t;

   beat_t         beats[$];
   logic [DW-1:0] exp_data[$];
   burst_t        blog[$];
   bit            active = 1'b0;
   bit            new_burst = 1'b0;
   int            gap = 0;
   int            done_in = 0;
   int            pop_cnt = 0;
   int            done_cnt = 0;
   int            n_chk = 0;
   int            n_pass = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   function automatic burst_t blog_at(input int i);
      burst_t r;
      r.addr = '0;
      r.bc   = '0;
      if (i >= 0 && i < blog.size()) r = blog[i];
      return r;
   endfunction

   // Per-cycle comparison against the transaction model (runs on the falling edge).
   task automatic cmp_cycle();
      bit    exp_wr;
      bit    exp_acc;
      beat_t b;
      int    len;
      int    bi;
      int    bc;
      burst_t lg;
      if (!rst) begin
         check("rst_write", avm_write, 0);
         check("rst_fifo_rd", fifo_rd, 0);
         check("rst_address", avm_address, 0);
         check("rst_burstcount", avm_burstcount, 0);
         check("rst_done", store_trans_done, 0);
         beats.delete();
         exp_data.delete();
         active  = 1'b0;
         gap     = 0;
         done_in = 0;
         return;
      end
      exp_wr  = active && gap == 0 && !fifo_empty && beats.size() > 0;
      exp_acc = exp_wr && !avm_waitrequest;
      check("avm_write", avm_write, exp_wr);
      check("fifo_rd", fifo_rd, exp_acc);
      if (exp_wr && avm_write) begin
         check("avm_address", avm_address, beats[0].addr);
         check("avm_burstcount", avm_burstcount, beats[0].bc);
         if (exp_data.size() > 0) check("avm_writedata", avm_writedata, exp_data[0]);
      end
      check("store_trans_done", store_trans_done, done_in == 1);
      if (store_trans_done) done_cnt++;
      if (fifo_rd) pop_cnt++;
      if (done_in == 1) active = 1'b0;
      if (done_in > 0) done_in--;
      if (gap > 0) gap--;
      if (exp_acc) begin
         b = beats.pop_front();
         if (exp_data.size() > 0) void'(exp_data.pop_front());
         if (new_burst) begin
            lg.addr = avm_address;
            lg.bc   = avm_burstcount;
            blog.push_back(lg);
         end
         new_burst = b.last;
         if (b.last) begin
            if (beats.size() == 0) done_in = 1;
            else gap = 1;
         end
      end
      if (push_req) exp_data.push_back(push_val);
      if (store_trans_start && !active) begin
         active    = 1'b1;
         new_burst = 1'b1;
         len       = int'(param_iolen);
         if (len == 0) begin
            done_in = 2;
         end else begin
            gap = 1;
            for (int k = 0; k < len; k++) begin
               bi     = k / BL;
               bc     = (len - bi * BL < BL) ? (len - bi * BL) : BL;
               b.addr = param_waddr + DW'(bi * BL * 4);
               b.bc   = BCW'(bc);
               b.last = (k == bi * BL + bc - 1);
               beats.push_back(b);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) begin
         push_req = 1'b1;
         push_val = $urandom;
         tick();
      end
      push_req = 1'b0;
   endtask

   task automatic start_txn(input logic [DW-1:0] addr, input int len);
      param_waddr       = addr;
      param_iolen       = AW'(len);
      store_trans_start = 1'b1;
      tick();
      store_trans_start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int max_cycles, input bit rand_wait);
      int c = 0;
      while (done_cnt == base && c < max_cycles) begin
         if (rand_wait) avm_waitrequest = 1'($urandom_range(0, 1));
         tick();
         c++;
      end
      avm_waitrequest = 1'b0;
      check("done_timeout", done_cnt != base, 1);
      repeat (3) tick();
   endtask

   task automatic check_bursts(input string tag, input int lb, input int n);
      check({tag, "_bursts"}, blog.size() - lb, n);
   endtask

   initial begin
      int pb;
      int lb;
      int db;
      int c;
      fork
         forever begin
            @(negedge clk);
            cmp_cycle();
         end
      join_none

      #1 rst = 1'b0;
      repeat (3) tick();
      check("reset_address", avm_address, 0);
      check("reset_burstcount", avm_burstcount, 0);
      check("byteenable", avm_byteenable, 4'hF);
      rst = 1'b1;
      tick();

      // 128 words from a full FIFO, no stalls
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      push_n(128);
      start_txn(32'h1000, 128);
      wait_done(db, 400, 1'b0);
      check("t1_pops", pop_cnt - pb, 128);
      check_bursts("t1", lb, 8);
      check("t1_b0_addr", blog_at(lb).addr, 32'h1000);
      check("t1_b1_addr", blog_at(lb + 1).addr, 32'h1040);
      check("t1_b7_addr", blog_at(lb + 7).addr, 32'h11C0);
      check("t1_b7_bc", blog_at(lb + 7).bc, 16);
      check("t1_done_cnt", done_cnt - db, 1);

      // short tail burst
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      push_n(20);
      start_txn(32'h0, 20);
      wait_done(db, 100, 1'b0);
      check("t2_pops", pop_cnt - pb, 20);
      check_bursts("t2", lb, 2);
      check("t2_b0_addr", blog_at(lb).addr, 32'h0);
      check("t2_b0_bc", blog_at(lb).bc, 16);
      check("t2_b1_addr", blog_at(lb + 1).addr, 32'h40);
      check("t2_b1_bc", blog_at(lb + 1).bc, 4);
      check("t2_done_cnt", done_cnt - db, 1);

      // random waitrequest stalls
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      push_n(128);
      start_txn(32'h2000, 128);
      wait_done(db, 1500, 1'b1);
      check("t3_pops", pop_cnt - pb, 128);
      check_bursts("t3", lb, 8);
      check("t3_b7_addr", blog_at(lb + 7).addr, 32'h21C0);
      check("t3_done_cnt", done_cnt - db, 1);

      // slow FIFO: one word every third cycle
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      start_txn(32'h3000, 16);
      for (int i = 0; i < 16; i++) begin
         push_req = 1'b1;
         push_val = $urandom;
         tick();
         push_req = 1'b0;
         tick();
         tick();
      end
      wait_done(db, 50, 1'b0);
      check("t4_pops", pop_cnt - pb, 16);
      check_bursts("t4", lb, 1);
      check("t4_b0_addr", blog_at(lb).addr, 32'h3000);
      check("t4_b0_bc", blog_at(lb).bc, 16);
      check("t4_done_cnt", done_cnt - db, 1);

      // zero-length transaction
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      start_txn(32'h500, 0);
      wait_done(db, 10, 1'b0);
      check("t5_pops", pop_cnt - pb, 0);
      check_bursts("t5", lb, 0);
      check("t5_done_cnt", done_cnt - db, 1);

      // address wrap across 2^32
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      push_n(20);
      start_txn(32'hFFFF_FFC0, 20);
      wait_done(db, 100, 1'b0);
      check("tw_b0_addr", blog_at(lb).addr, 32'hFFFF_FFC0);
      check("tw_b1_addr", blog_at(lb + 1).addr, 32'h0);
      check("tw_b1_bc", blog_at(lb + 1).bc, 4);
      check("tw_pops", pop_cnt - pb, 20);

      // reset mid-burst, then a clean transaction with an ignored extra start
      pb = pop_cnt;
      push_n(16);
      start_txn(32'h4000, 16);
      c = 0;
      while (pop_cnt < pb + 5 && c < 100) begin
         tick();
         c++;
      end
      check("t6_pop_wait", pop_cnt >= pb + 5, 1);
      #1 rst = 1'b0;
      #1;
      check("t6_async_write", avm_write, 0);
      check("t6_async_fifo_rd", fifo_rd, 0);
      check("t6_async_address", avm_address, 0);
      check("t6_async_burstcount", avm_burstcount, 0);
      check("t6_async_done", store_trans_done, 0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      pb = pop_cnt; lb = blog.size(); db = done_cnt;
      push_n(4);
      start_txn(32'h200, 4);
      tick();
      start_txn(32'h999, 7);
      wait_done(db, 50, 1'b0);
      repeat (5) tick();
      check("t6_pops", pop_cnt - pb, 4);
      check_bursts("t6", lb, 1);
      check("t6_b0_addr", blog_at(lb).addr, 32'h200);
      check("t6_b0_bc", blog_at(lb).bc, 4);
      check("t6_done_cnt", done_cnt - db, 1);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
